// File: rtl/res_reader.sv
// res_reader: AHB-Lite reader for a result FIFO, with STATUS and COUNT registers.
// Build option: define RES_READER_SIGN_EXT_EN to sign-extend RESULT data from bit 15.
module res_reader #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hsel,
  input  logic [3:0]  haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_renable
);
  typedef enum logic [2:0] {IDLE, POP, DATA, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic unf_q, unf_d, clr_q, clr_d;
  logic [1:0] rsel_q, rsel_d;
  logic [31:0] hrdata_q, result;
  logic acc, res_rd, err, unused_ok;
  // Address-phase decode; transfers are only taken while this slave is ready
  always_comb begin
    acc = hsel & htrans[1] & hready & hreadyout;
    res_rd = acc & ~hwrite & (haddr[3:2] == 2'd0);
    err = acc & (((haddr[3:2] == 2'd0) & (hwrite | fifo_empty)) | ((haddr[3:2] == 2'd1) & hwrite) | (haddr[3:2] == 2'd3));
    unused_ok = ^{hwdata, haddr[1:0]};
  end
  // State register and datapath flops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      unf_q <= 1'b0;
      clr_q <= 1'b0;
      rsel_q <= 2'd0;
      hrdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      unf_q <= unf_d;
      clr_q <= clr_d;
      rsel_q <= rsel_d;
      hrdata_q <= hrdata;
    end
  end
  // Next state: POP and ERR1 are fixed one-cycle steps, otherwise follow the new transfer
  always_comb begin
    state_d = (state_q == POP) ? DATA : (state_q == ERR1) ? ERR2 : (res_rd & ~fifo_empty) ? POP : err ? ERR1 : IDLE;
  end
  // FSM outputs
  always_comb begin
    hreadyout = ~((state_q == POP) | (state_q == ERR1));
    hresp = (state_q == ERR1) | (state_q == ERR2);
    fifo_renable = state_q == POP;
  end
  // Read mux, register data phases and counter/underflow updates
  always_comb begin
`ifdef RES_READER_SIGN_EXT_EN
    result = {{16{fifo_data[15]}}, fifo_data};
`else
    result = {16'h0000, fifo_data};
`endif
    hrdata = (state_q == DATA) ? result : (rsel_q == 2'd1) ? {30'd0, unf_q, fifo_empty} : (rsel_q == 2'd2) ? 32'(count_q) : hrdata_q;
    rsel_d = (acc & ~hwrite & (haddr[3:2] == 2'd1)) ? 2'd1 : (acc & ~hwrite & (haddr[3:2] == 2'd2)) ? 2'd2 : 2'd0;
    clr_d = acc & hwrite & (haddr[3:2] == 2'd2);
    count_d = clr_q ? '0 : ((state_q == DATA) & ~&count_q) ? count_q + 1'b1 : count_q;
    unf_d = (res_rd & fifo_empty) | (unf_q & ~clr_q);
  end
endmodule

// File: tb/tb_res_reader.sv
// tb_res_reader: directed table-driven bench for res_reader with a small FIFO model.
module tb_res_reader;
  logic clk = 1'b0, n_rst = 1'b0, hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [3:0] haddr = 4'h0;
  logic [1:0] htrans = 2'b00;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata;
  logic hreadyout, hresp, fifo_empty, fifo_renable;
  logic [15:0] fifo_data = 16'h0;
  logic [15:0] fq[$], eq[$];
  int pops = 0, nchk = 0, nfail = 0;

  typedef struct {
    logic [3:0] addr;
    logic wr;
    logic [31:0] wdata;
    logic push;
    logic [15:0] pval;
    logic [31:0] rd;
    logic resp;
    int waits;
    int pops;
  } vec_t;
  vec_t tbl[17];

  res_reader #(.CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_renable(fifo_renable)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fq.size() == 0);

  always @(posedge clk) begin
    if (fifo_renable) pops <= pops + 1;
    if (fifo_renable && fq.size() > 0) fifo_data <= fq.pop_front();
  end

  function automatic logic [31:0] ext(input logic [15:0] v);
`ifdef RES_READER_SIGN_EXT_EN
    return {{16{v[15]}}, v};
`else
    return {16'h0000, v};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    fq.push_back(v);
    eq.push_back(v);
  endtask

  task automatic xact(input vec_t v, input string nm);
    int w, p0;
    if (v.push) push(v.pval);
    p0 = pops;
    w = 0;
    hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr;
    cyc();
    hsel = 1'b0; htrans = 2'b00; hwdata = v.wdata;
    while (!hreadyout && w < 4) begin
      chk({nm, " wait-resp"}, 32'(hresp), 32'(v.resp));
      cyc();
      w++;
    end
    if (v.push && !v.resp) void'(eq.pop_front());
    chk({nm, " waits"}, 32'(w), 32'(v.waits));
    chk({nm, " resp"}, 32'(hresp), 32'(v.resp));
    if (!v.wr && !v.resp) chk({nm, " rdata"}, hrdata, v.rd);
    chk({nm, " pops"}, 32'(pops - p0), 32'(v.pops));
  endtask

  task automatic pipe(input int n, input string nm);
    int c, got;
    logic [15:0] e;
    c = 0;
    got = 0;
    hsel = 1'b1; htrans = 2'b10; haddr = 4'h0; hwrite = 1'b0;
    while (got < n && c < 4 * n + 4) begin
      cyc();
      c++;
      if (hreadyout) begin
        e = (eq.size() > 0) ? eq.pop_front() : 16'hxxxx;
        chk($sformatf("%s data%0d", nm, got), hrdata, ext(e));
        got++;
        if (got == n) begin
          hsel = 1'b0;
          htrans = 2'b00;
        end
      end else chk($sformatf("%s pop%0d", nm, got), 32'(fifo_renable), 32'd1);
    end
    hsel = 1'b0;
    htrans = 2'b00;
    chk({nm, " cycles"}, 32'(c), 32'(2 * n));
  endtask

  initial begin
    int p0;
    tbl[0]  = '{4'h4, 1'b0, 32'h0, 1'b0, 16'h0, 32'h1, 1'b0, 0, 0};
    tbl[1]  = '{4'h0, 1'b0, 32'h0, 1'b1, 16'h8001, ext(16'h8001), 1'b0, 1, 1};
    tbl[2]  = '{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'h1, 1'b0, 0, 0};
    tbl[3]  = '{4'h0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b1, 1, 0};
    tbl[4]  = '{4'h4, 1'b0, 32'h0, 1'b0, 16'h0, 32'h3, 1'b0, 0, 0};
    tbl[5]  = '{4'h4, 1'b1, 32'h5, 1'b0, 16'h0, 32'h0, 1'b1, 1, 0};
    tbl[6]  = '{4'h4, 1'b0, 32'h0, 1'b0, 16'h0, 32'h3, 1'b0, 0, 0};
    tbl[7]  = '{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'h1, 1'b0, 0, 0};
    tbl[8]  = '{4'h8, 1'b1, 32'hDEAD, 1'b0, 16'h0, 32'h0, 1'b0, 0, 0};
    tbl[9]  = '{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 0, 0};
    tbl[10] = '{4'h4, 1'b0, 32'h0, 1'b0, 16'h0, 32'h1, 1'b0, 0, 0};
    tbl[11] = '{4'hC, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b1, 1, 0};
    tbl[12] = '{4'h0, 1'b1, 32'h1, 1'b0, 16'h0, 32'h0, 1'b1, 1, 0};
    tbl[13] = '{4'h0, 1'b0, 32'h0, 1'b1, 16'h7FFF, 32'h7FFF, 1'b0, 1, 1};
    tbl[14] = '{4'h4, 1'b0, 32'h0, 1'b0, 16'h0, 32'h1, 1'b0, 0, 0};
    tbl[15] = '{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'h1, 1'b0, 0, 0};
    tbl[16] = '{4'hC, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 1'b1, 1, 0};
    #3;
    chk("rst hrdata", hrdata, 32'h0);
    chk("rst hreadyout", 32'(hreadyout), 32'd1);
    chk("rst hresp", 32'(hresp), 32'd0);
    chk("rst renable", 32'(fifo_renable), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    cyc();
    for (int i = 0; i < 17; i++) xact(tbl[i], $sformatf("vec%0d", i));
    xact('{4'h8, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 0, 0}, "clr1");
    push(16'h0001); push(16'h0002); push(16'h0003);
    pipe(3, "pipe3");
    xact('{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'h3, 1'b0, 0, 0}, "count3");
    xact('{4'h8, 1'b1, 32'hFFFF, 1'b0, 16'h0, 32'h0, 1'b0, 0, 0}, "clr2");
    for (int i = 0; i < 17; i++) push(16'h0010 + 16'(i));
    pipe(17, "pipe17");
    xact('{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'hF, 1'b0, 0, 0}, "count-sat");
    fq.push_back(16'h1234);
    p0 = pops;
    hsel = 1'b1; htrans = 2'b10; haddr = 4'h0; hwrite = 1'b0;
    cyc();
    hsel = 1'b0; htrans = 2'b00;
    chk("pop renable", 32'(fifo_renable), 32'd1);
    chk("pop hreadyout", 32'(hreadyout), 32'd0);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst hrdata", hrdata, 32'h0);
    chk("midrst hreadyout", 32'(hreadyout), 32'd1);
    chk("midrst hresp", 32'(hresp), 32'd0);
    chk("midrst renable", 32'(fifo_renable), 32'd0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    cyc();
    chk("midrst pops", 32'(pops - p0), 32'd0);
    xact('{4'h8, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 0, 0}, "count-after-rst");
    xact('{4'h4, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 0, 0}, "status-after-rst");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
